// File: rtl/uart_pkg.sv
// +------------------------------------------------------------------+
// | Module  : uart_pkg                                               |
// | Brief   : Shared UART types and constants (data width, TX FIFO   |
// |           drain FSM states, default FIFO depth).                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int TX_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } tx_fifo_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
// +------------------------------------------------------------------+
// | Module  : uart_fifo_mem                                          |
// | Brief   : Byte storage array with wrapping read/write pointers   |
// |           and an entry count; callers gate push/pop themselves.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = TX_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk16x,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic [AW:0]            level
);

  logic [UART_DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_level;

  // Storage is not reset; contents are meaningless once the pointers clear.
  always_ff @(posedge clk16x) begin
    if (push && !clr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk16x) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign level   = r_level;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// +------------------------------------------------------------------+
// | Module  : uart_tx_fifo                                           |
// | Brief   : CPU-side byte FIFO that drains into the UART           |
// |           transmitter via its active-low wrn/d_in strobe.        |
// | Config  : UART_TX_FIFO_OVF_EN enables the sticky overflow flag.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = TX_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk16x,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            level,
  output logic                   overflow,
  input  logic                   ovf_clr,
  input  logic                   t_empty,
  output logic                   wrn,
  output logic [UART_DATA_W-1:0] d_in
);

  localparam logic [AW:0] C_FULL_LEVEL = (AW+1)'(DEPTH);

  tx_fifo_state_t         r_state;
  logic                   w_push;
  logic                   w_pop;
  logic [UART_DATA_W-1:0] w_rd_data;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign full   = (level == C_FULL_LEVEL);
  assign empty  = (level == '0);
  assign w_push = wr_en && !full;
  assign w_pop  = (r_state == IDLE) && !empty && t_empty;

  uart_fifo_mem #(
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_mem (
    .clk16x  (clk16x),
    .clr     (clr),
    .push    (w_push),
    .pop     (w_pop),
    .wr_data (wr_data),
    .rd_data (w_rd_data),
    .level   (level)
  );

  always_ff @(posedge clk16x) begin
    if (clr) begin
      r_state <= IDLE;
      wrn     <= 1'b1;
      d_in    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            wrn     <= 1'b0;
            d_in    <= w_rd_data;
            r_state <= STROBE;
          end
        end
        STROBE: begin
          wrn     <= 1'b1;
          r_state <= WAIT_LO;
        end
        // Wait for the transmitter to take the byte, then to become ready again.
        WAIT_LO: begin
          if (!t_empty) begin
            r_state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (t_empty) begin
            r_state <= IDLE;
          end
        end
        default: begin
          wrn     <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic r_overflow;

  // A dropped push outranks a simultaneous clear.
  always_ff @(posedge clk16x) begin
    if (clr) begin
      r_overflow <= 1'b0;
    end else if (wr_en && full) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
`else
  logic w_ovf_clr_unused;

  assign w_ovf_clr_unused = ovf_clr;
  assign overflow         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// +------------------------------------------------------------------+
// | Module  : tb_uart_tx_fifo                                        |
// | Brief   : Directed self-checking bench for uart_tx_fifo.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

`ifdef UART_TX_FIFO_OVF_EN
  localparam logic C_OVF = 1'b1;
`else
  localparam logic C_OVF = 1'b0;
`endif

  logic          clk16x = 1'b0;
  logic          clr;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          ovf_clr;
  logic          t_empty;
  logic          wrn;
  logic [7:0]    d_in;

  int checks = 0;
  int passed = 0;
  int tx_cnt = 0;

  always #5 clk16x = ~clk16x;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk16x   (clk16x),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .t_empty  (t_empty),
    .wrn      (wrn),
    .d_in     (d_in)
  );

  // Strobe monitor: records every byte handed to the transmitter
  int         cyc = 0;
  logic       te_prev = 1'b1;
  int         last_strobe = -100;
  int         gap_err = 0;
  int         te_viol = 0;
  logic [7:0] got [$];

  always @(posedge clk16x) begin
    cyc++;
    te_prev = t_empty;
  end

  always @(negedge clk16x) begin
    if (wrn === 1'b0) begin
      got.push_back(d_in);
      if (cyc - last_strobe < 4) gap_err++;
      if (te_prev !== 1'b1) te_viol++;
      last_strobe = cyc;
    end
  end

  task automatic do_reset(input logic te);
    clr     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    ovf_clr = 1'b0;
    t_empty = te;
    tx_cnt  = 0;
    repeat (2) @(negedge clk16x);
    clr = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk16x);
    wr_en   = 1'b0;
  endtask

  // Transmitter stand-in: drops t_empty on a strobe, raises it two cycles later
  task automatic tx_step();
    if (wrn === 1'b0) begin
      t_empty = 1'b0;
      tx_cnt  = 2;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) t_empty = 1'b1;
    end
  endtask

  task automatic run_tx(input int n);
    repeat (n) begin
      @(negedge clk16x);
      tx_step();
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0; t_empty = 1'b1;
    repeat (3) @(negedge clk16x);
    checks++; if (wrn !== 1'b1) $display("FAIL reset_wrn: got %b expected 1", wrn); else passed++;
    checks++; if (d_in !== 8'h00) $display("FAIL reset_d_in: got %h expected 00", d_in); else passed++;
    checks++; if (level !== 5'd0) $display("FAIL reset_level: got %0d expected 0", level); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else passed++;
    checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else passed++;
    clr = 1'b0;
    @(negedge clk16x);
  endtask

  task automatic test_single_strobe();
    int base;
    do_reset(1'b1);
    base = got.size();
    push_byte(8'h55);
    checks++; if (level !== 5'd1) $display("FAIL single_level_k: got %0d expected 1", level); else passed++;
    checks++; if (wrn !== 1'b1) $display("FAIL single_wrn_k: got %b expected 1", wrn); else passed++;
    checks++; if (empty !== 1'b0) $display("FAIL single_empty_k: got %b expected 0", empty); else passed++;
    @(negedge clk16x);
    checks++; if (wrn !== 1'b0) $display("FAIL single_wrn_k1: got %b expected 0", wrn); else passed++;
    checks++; if (d_in !== 8'h55) $display("FAIL single_d_in_k1: got %h expected 55", d_in); else passed++;
    checks++; if (level !== 5'd0) $display("FAIL single_level_k1: got %0d expected 0", level); else passed++;
    @(negedge clk16x);
    checks++; if (wrn !== 1'b1) $display("FAIL single_wrn_k2: got %b expected 1", wrn); else passed++;
    checks++; if (d_in !== 8'h55) $display("FAIL single_d_in_hold: got %h expected 55", d_in); else passed++;
    t_empty = 1'b0;
    repeat (2) @(negedge clk16x);
    t_empty = 1'b1;
    repeat (6) @(negedge clk16x);
    checks++; if (got.size() - base !== 1) $display("FAIL single_strobe_count: got %0d expected 1", got.size() - base); else passed++;
    checks++; if (d_in !== 8'h55) $display("FAIL single_d_in_after: got %h expected 55", d_in); else passed++;
  endtask

  task automatic test_back_to_back();
    int base, g0, t0;
    do_reset(1'b0);
    base = got.size(); g0 = gap_err; t0 = te_viol;
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    checks++; if (level !== 5'd3) $display("FAIL b2b_level_queued: got %0d expected 3", level); else passed++;
    t_empty = 1'b1;
    run_tx(60);
    checks++; if (got.size() - base !== 3) $display("FAIL b2b_count: got %0d expected 3", got.size() - base); else passed++;
    if (got.size() - base == 3) begin
      checks++; if (got[base] !== 8'h01) $display("FAIL b2b_byte0: got %h expected 01", got[base]); else passed++;
      checks++; if (got[base+1] !== 8'h02) $display("FAIL b2b_byte1: got %h expected 02", got[base+1]); else passed++;
      checks++; if (got[base+2] !== 8'h03) $display("FAIL b2b_byte2: got %h expected 03", got[base+2]); else passed++;
    end
    checks++; if (gap_err - g0 !== 0) $display("FAIL b2b_spacing: got %0d short gaps expected 0", gap_err - g0); else passed++;
    checks++; if (te_viol - t0 !== 0) $display("FAIL b2b_strobe_while_busy: got %0d expected 0", te_viol - t0); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL b2b_empty_end: got %b expected 1", empty); else passed++;
  endtask

  task automatic test_fill_overflow();
    int base, nbad;
    logic [7:0] exp_b;
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    checks++; if (full !== 1'b1) $display("FAIL fill_full: got %b expected 1", full); else passed++;
    checks++; if (level !== 5'd16) $display("FAIL fill_level: got %0d expected 16", level); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL fill_no_ovf_yet: got %b expected 0", overflow); else passed++;
    push_byte(8'hAA);
    checks++; if (level !== 5'd16) $display("FAIL ovf_level_kept: got %0d expected 16", level); else passed++;
    checks++; if (overflow !== C_OVF) $display("FAIL ovf_set: got %b expected %b", overflow, C_OVF); else passed++;
    ovf_clr = 1'b1;
    push_byte(8'hAA);
    checks++; if (overflow !== C_OVF) $display("FAIL ovf_set_beats_clr: got %b expected %b", overflow, C_OVF); else passed++;
    @(negedge clk16x);
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_clr: got %b expected 0", overflow); else passed++;
    push_byte(8'hAA);
    checks++; if (overflow !== C_OVF) $display("FAIL ovf_reset_again: got %b expected %b", overflow, C_OVF); else passed++;
    base = got.size();
    t_empty = 1'b1;
    run_tx(200);
    checks++; if (got.size() - base !== 16) $display("FAIL drain_count: got %0d expected 16", got.size() - base); else passed++;
    if (got.size() - base == 16) begin
      nbad = 0;
      for (int i = 0; i < 16; i++) begin
        exp_b = 8'h10 + 8'(i);
        checks++;
        if (got[base+i] !== exp_b) begin
          $display("FAIL drain_byte%0d: got %h expected %h", i, got[base+i], exp_b);
          nbad++;
        end else passed++;
      end
    end
    checks++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b expected 1", empty); else passed++;
    checks++; if (overflow !== C_OVF) $display("FAIL ovf_sticky: got %b expected %b", overflow, C_OVF); else passed++;
  endtask

  task automatic test_push_pop_wrap();
    int base, pushed;
    logic [7:0] exp_b;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) push_byte(8'h20 + 8'(i));
    checks++; if (level !== 5'd5) $display("FAIL pp_level_before: got %0d expected 5", level); else passed++;
    base    = got.size();
    wr_en   = 1'b1;
    wr_data = 8'h25;
    t_empty = 1'b1;
    @(negedge clk16x);
    wr_en = 1'b0;
    checks++; if (level !== 5'd5) $display("FAIL pp_level_same: got %0d expected 5", level); else passed++;
    checks++; if (wrn !== 1'b0) $display("FAIL pp_strobe: got %b expected 0", wrn); else passed++;
    checks++; if (d_in !== 8'h20) $display("FAIL pp_d_in: got %h expected 20", d_in); else passed++;
    tx_step();
    pushed = 6;
    repeat (500) begin
      @(negedge clk16x);
      tx_step();
      if (pushed < 46 && !full) begin
        wr_en   = 1'b1;
        wr_data = 8'h20 + 8'(pushed);
        pushed++;
      end else begin
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0;
    checks++; if (got.size() - base !== 46) $display("FAIL wrap_count: got %0d expected 46", got.size() - base); else passed++;
    if (got.size() - base == 46) begin
      for (int i = 0; i < 46; i++) begin
        exp_b = 8'h20 + 8'(i);
        checks++;
        if (got[base+i] !== exp_b) $display("FAIL wrap_byte%0d: got %h expected %h", i, got[base+i], exp_b);
        else passed++;
      end
    end
  endtask

  task automatic test_clr_mid();
    int base;
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) push_byte(8'h31 + 8'(i));
    base    = got.size();
    t_empty = 1'b1;
    @(negedge clk16x);
    checks++; if (wrn !== 1'b0) $display("FAIL clr_pre_strobe: got %b expected 0", wrn); else passed++;
    checks++; if (level !== 5'd3) $display("FAIL clr_pre_level: got %0d expected 3", level); else passed++;
    t_empty = 1'b0;
    @(negedge clk16x);
    clr = 1'b1;
    @(negedge clk16x);
    clr = 1'b0;
    checks++; if (wrn !== 1'b1) $display("FAIL clr_wrn: got %b expected 1", wrn); else passed++;
    checks++; if (level !== 5'd0) $display("FAIL clr_level: got %0d expected 0", level); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL clr_empty: got %b expected 1", empty); else passed++;
    t_empty = 1'b1;
    repeat (3) @(negedge clk16x);
    t_empty = 1'b0;
    repeat (3) @(negedge clk16x);
    t_empty = 1'b1;
    repeat (10) @(negedge clk16x);
    checks++; if (got.size() - base !== 1) $display("FAIL clr_no_more_strobes: got %0d expected 1", got.size() - base); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_strobe();
    test_back_to_back();
    test_fill_overflow();
    test_push_pop_wrap();
    test_clr_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
